fft_loader: RTL and testbench

- Input-side front end of the 2048-point FFT: the writer of the frame memory that the FFT engine later reads.
- Accepts a stream of real signed samples and multiplies each by its Hann window coefficient.
- Writes each windowed sample as a complex word at its bit-reversed address in the FFT frame RAM.
- After 2048 writes it pulses fft_start, then holds off input until the FFT signals done.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_loader_if.sv | 30 +++
 rtl/fft_loader.sv | 114 +++++++++++
 tb/tb_fft_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input front end: frame size, loader
// state encoding and the bit-reversal used to address the frame RAM.
package fft_pkg;

    localparam int N     = 2048;
    localparam int LOG2N = 11;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } ld_state_e;

    // Mirror an 11-bit sample index into its bit-reversed RAM address.
    function automatic logic [LOG2N-1:0] bitrev11(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_loader_if.sv
// Sample stream, window LUT, frame RAM write port and FFT handshake of the
// loader. The slave side is the loader itself; master is whoever drives it.
interface fft_loader_if #(
    parameter int WIDTH = 16
);
    import fft_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-6:0]  in_sample;
    logic [LOG2N-1:0]         win_idx;
    logic [WIDTH-1:0]         win_coef;
    logic                     we;
    logic [LOG2N-1:0]         wadr;
    logic [2*WIDTH-1:0]       wd;
    logic                     fft_start;
    logic                     fft_done;
    logic                     busy;

    modport slave (
        input  in_valid, in_sample, win_coef, fft_done,
        output in_ready, win_idx, we, wadr, wd, fft_start, busy
    );

    modport master (
        output in_valid, in_sample, win_coef, fft_done,
        input  in_ready, win_idx, we, wadr, wd, fft_start, busy
    );

endinterface

// File: rtl/fft_loader.sv
// Front end of the 2048-point FFT: windows each real input sample with its
// Hann coefficient and writes it as {re, 0} at the bit-reversed address of
// the frame RAM. After a full frame it pulses fft_start and stalls the input
// until the engine reports fft_done.
module fft_loader
    import fft_pkg::*;
#(
    parameter int width = 16
) (
    input  logic       clk,
    input  logic       reset,
    fft_loader_if.slave bus
);

    ld_state_e               state_q, state_d;
    logic [LOG2N-1:0]        count_q, count_d;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    fft_start_q;
    logic                    accept;

    // vld_pipe_q[0]: sample/index registered, coefficient arriving this cycle
    // vld_pipe_q[1]: RAM write presented (this is the we output)
    logic [1:0]              vld_pipe_q;
    logic [1:0]              last_pipe_q;
    logic signed [width-6:0] s1_sample_q;
    logic [LOG2N-1:0]        s1_idx_q;
    logic [LOG2N-1:0]        wadr_q;
    logic [2*width-1:0]      wd_q;

    logic signed [2*width-5:0] prod;
    logic signed [width-1:0]   re;

    // in_ready is only ever high in FILL, so accept needs no state decode.
    assign accept = bus.in_valid && in_ready_q;

    // Coefficient is a positive Q0.width fraction: zero-extend before the
    // signed multiply, then an arithmetic shift floors back to sample scale.
    assign prod = s1_sample_q * $signed({1'b0, bus.win_coef});
    assign re   = width'(prod >>> width);

    // Next-state and frame counter; the counter rests at N-1 until the
    // engine releases the frame, so the wrap happens only on WAIT->FILL.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (count_q == LOG2N'(N-1)) state_d = FLUSH;
                    else                        count_d = count_q + 1'b1;
                end
            end
            FLUSH: begin
                // Leave once the final word is on the write port so the RAM
                // has captured it by the time fft_start is seen.
                if (vld_pipe_q[1] && last_pipe_q[1]) state_d = START;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.fft_done) begin
                    state_d = FILL;
                    count_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, control outputs registered from next state, and the two-stage
    // window/write pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            fft_start_q <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            s1_sample_q <= '0;
            s1_idx_q    <= '0;
            wadr_q      <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            in_ready_q  <= (state_d == FILL);
            busy_q      <= (state_d != FILL);
            fft_start_q <= (state_d == START);

            vld_pipe_q  <= {vld_pipe_q[0], accept};
            last_pipe_q <= {last_pipe_q[0] & vld_pipe_q[0],
                            accept && (count_q == LOG2N'(N-1))};
            if (accept) begin
                s1_sample_q <= bus.in_sample;
                s1_idx_q    <= count_q;
            end
            if (vld_pipe_q[0]) begin
                wadr_q <= bitrev11(s1_idx_q);
                wd_q   <= {re, {width{1'b0}}};
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.fft_start = fft_start_q;
    assign bus.win_idx   = count_q;
    assign bus.we        = vld_pipe_q[1];
    assign bus.wadr      = wadr_q;
    assign bus.wd        = wd_q;

endmodule

// File: tb/tb_fft_loader.sv
// Scoreboard bench for fft_loader: the driver pushes the expected RAM word
// for every accepted sample, a negedge monitor pops and compares on each we.
module tb_fft_loader;

    localparam int W = 16;

    typedef struct packed {
        logic [10:0] adr;
        logic [31:0] wd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_loader_if #(.WIDTH(W)) bus ();

    fft_loader #(.width(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    int   model_idx = 0;
    int   we_cnt    = 0;
    int   start_cnt = 0;
    logic written [0:2047];
    logic [15:0] coef_tab [0:2047];
    logic last_we_prev = 1'b0;
    logic start_prev   = 1'b0;

    // Hand-computed vectors: re = floor(sample * coef / 65536)
    logic signed [10:0] vs [0:7];
    logic [15:0]        vc [0:7];
    logic signed [15:0] vr [0:7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] rev(input logic [10:0] a);
        logic [10:0] r = '0;
        logic [10:0] t = a;
        for (int i = 0; i < 11; i++) begin
            r = {r[9:0], t[0]};
            t = t >> 1;
        end
        return r;
    endfunction

    // Registered Hann LUT stand-in
    always @(posedge clk) bus.win_coef <= coef_tab[bus.win_idx];

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (bus.we === 1'b1) begin
            we_cnt++;
            chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("wadr", 64'(bus.wadr), 64'(e.adr));
                chk("wd", 64'(bus.wd), 64'(e.wd));
            end
            chk("addr_unique", 64'(written[bus.wadr]), 64'd0);
            written[bus.wadr] = 1'b1;
        end
        if (bus.fft_start === 1'b1) begin
            start_cnt++;
            chk("start_after_last_we", 64'(last_we_prev), 64'd1);
            chk("start_one_cycle", 64'(start_prev), 64'd0);
        end
        last_we_prev = (bus.we === 1'b1) && (bus.wadr == 11'h7FF);
        start_prev   = (bus.fft_start === 1'b1);
    end

    task automatic clear_frame();
        for (int i = 0; i < 2048; i++) written[i] = 1'b0;
        model_idx = 0;
        we_cnt    = 0;
    endtask

    task automatic send(input logic signed [10:0] s, input logic [15:0] c,
                        input logic signed [15:0] re, input int gap);
        exp_t e;
        int   n = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        coef_tab[model_idx] = c;
        bus.in_valid  = 1'b1;
        bus.in_sample = s;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) begin
            $display("FAIL accept_timeout actual=in_ready_low expected=accept_within_50");
            failures++;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "stalled");
        end
        e.adr = rev(11'(model_idx));
        e.wd  = {re, 16'h0000};
        sbq.push_back(e);
        model_idx++;
        @(posedge clk); #1;
    endtask

    task automatic frame_const(input int n);
        for (int i = 0; i < n; i++) send(11'sd1000, 16'hFFFF, 16'sd999, 0);
    endtask

    task automatic wait_start(input int expected);
        int n = 0;
        while (start_cnt < expected && n < 50) begin @(posedge clk); #1; n++; end
        chk("fft_start_seen", 64'(start_cnt), 64'(expected));
        repeat (5) begin @(posedge clk); #1; end
        chk("single_start", 64'(start_cnt), 64'(expected));
    endtask

    task automatic pulse_done();
        bus.fft_done = 1'b1;
        @(posedge clk); #1;
        bus.fft_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int wcount;
        vs[0] = 11'sd1000;  vc[0] = 16'hFFFF; vr[0] = 16'sd999;
        vs[1] = -11'sd1000; vc[1] = 16'h8000; vr[1] = -16'sd500;
        vs[2] = -11'sd1;    vc[2] = 16'h0001; vr[2] = -16'sd1;
        vs[3] = -11'sd1024; vc[3] = 16'hFFFF; vr[3] = -16'sd1024;
        vs[4] = 11'sd1023;  vc[4] = 16'hFFFF; vr[4] = 16'sd1022;
        vs[5] = 11'sd0;     vc[5] = 16'hFFFF; vr[5] = 16'sd0;
        vs[6] = 11'sd500;   vc[6] = 16'h4000; vr[6] = 16'sd125;
        vs[7] = 11'sd1;     vc[7] = 16'hFFFF; vr[7] = 16'sd0;
        for (int i = 0; i < 2048; i++) coef_tab[i] = 16'h0000;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.fft_done  = 1'b0;
        clear_frame();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_we", 64'(bus.we), 64'd0);
        chk("rst_wadr", 64'(bus.wadr), 64'd0);
        chk("rst_wd", 64'(bus.wd), 64'd0);
        chk("rst_fft_start", 64'(bus.fft_start), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_win_idx", 64'(bus.win_idx), 64'd0);
        reset = 1'b0;

        // Frame 1: contiguous 1000 * 0xFFFF; input stays valid into WAIT
        frame_const(2048);
        wait_start(1);
        chk("f1_we_count", 64'(we_cnt), 64'd2048);
        chk("f1_in_ready_after", 64'(bus.in_ready), 64'd0);
        chk("f1_busy_after", 64'(bus.busy), 64'd1);

        // WAIT holds off input for 100 cycles despite in_valid
        wcount = we_cnt;
        repeat (100) begin @(posedge clk); #1; end
        chk("wait_no_we", 64'(we_cnt), 64'(wcount));
        chk("wait_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        pulse_done();
        chk("done_in_ready", 64'(bus.in_ready), 64'd1);
        chk("done_busy", 64'(bus.busy), 64'd0);
        chk("done_win_idx", 64'(bus.win_idx), 64'd0);

        // Frame 2: vector table, random gaps, stray fft_done in FILL and FLUSH
        clear_frame();
        for (int i = 0; i < 2048; i++) begin
            if (i == 500) begin
                bus.in_valid = 1'b0;
                pulse_done();
            end
            send(vs[i % 8], vc[i % 8], vr[i % 8], int'($urandom_range(0, 1)));
        end
        bus.in_valid = 1'b0;
        pulse_done();
        wait_start(2);
        chk("f2_we_count", 64'(we_cnt), 64'd2048);
        wcount = 0;
        for (int i = 0; i < 2048; i++) if (written[i] === 1'b1) wcount++;
        chk("f2_all_addrs", 64'(wcount), 64'd2048);
        pulse_done();

        // Frame 3: reset mid-frame after 700 accepts
        clear_frame();
        frame_const(700);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_we", 64'(bus.we), 64'd0);
        chk("midrst_win_idx", 64'(bus.win_idx), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;
        sbq.delete();
        clear_frame();

        // Frame 4: completes normally with a single start
        frame_const(2048);
        bus.in_valid = 1'b0;
        wait_start(3);
        chk("f4_we_count", 64'(we_cnt), 64'd2048);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
